// File: rtl/branch_resolve_unit_if.sv
// Bundle of the ID-lookup, EX-resolve and result signals of the branch resolve unit.
// The slave modport is the unit's view. The master modport is the pipeline's view.
interface branch_resolve_unit_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          id_pc;
  logic                 pred_taken;
  logic                 ex_valid;
  logic [31:0]          ex_pc;
  logic [WIDTH-1:0]     ex_val1;
  logic [WIDTH-1:0]     ex_val2;
  logic [2:0]           ex_branch_type;
  logic                 ex_pred_taken;
  logic                 stall;
  logic                 flush;
  logic                 res_valid;
  logic                 res_taken;
  logic                 mispredict;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output id_pc, ex_valid, ex_pc, ex_val1, ex_val2, ex_branch_type,
           ex_pred_taken, stall, flush,
    input  pred_taken, res_valid, res_taken, mispredict, branch_count,
           mispredict_count
  );

  modport slave (
    input  id_pc, ex_valid, ex_pc, ex_val1, ex_val2, ex_branch_type,
           ex_pred_taken, stall, flush,
    output pred_taken, res_valid, res_taken, mispredict, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch outcome resolution in EX, with a 2-bit saturating-counter BHT for ID-stage
// prediction, a registered result and saturating statistics counters.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEZ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_JMP  = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BLT  = 3'b101,
    BR_BGE  = 3'b110,
    BR_BLTU = 3'b111
  } br_type_e;

  function automatic logic [1:0] bht_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [1:0]              bht [BHT_DEPTH];
  logic [IDX_W-1:0]        id_idx;
  logic [IDX_W-1:0]        ex_idx;
  logic signed [WIDTH-1:0] val1_s;
  logic signed [WIDTH-1:0] val2_s;
  br_type_e                type_p0;
  logic                    taken_p0;
  logic                    active_p0;
  logic                    cond_p0;
  logic                    mispred_p0;

  logic                    res_valid_p1;
  logic                    res_taken_p1;
  logic                    mispredict_p1;
  logic [CNT_WIDTH-1:0]    branch_cnt_p1;
  logic [CNT_WIDTH-1:0]    mispred_cnt_p1;

  logic                    unused_pc_bits;
  assign unused_pc_bits = ^{bus.id_pc[31:IDX_W+2], bus.id_pc[1:0],
                            bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

  assign id_idx  = bus.id_pc[IDX_W+1:2];
  assign ex_idx  = bus.ex_pc[IDX_W+1:2];
  assign val1_s  = bus.ex_val1;
  assign val2_s  = bus.ex_val2;
  assign type_p0 = br_type_e'(bus.ex_branch_type);

  // No bypass: an entry being updated this cycle still predicts its old value
  assign bus.pred_taken = bht[id_idx][1];

  // Stage p0: resolve the EX instruction
  always_comb begin
    taken_p0 = 1'b0;
    case (type_p0)
      BR_BEZ:  taken_p0 = (bus.ex_val1 == '0);
      BR_BNE:  taken_p0 = (bus.ex_val1 != bus.ex_val2);
      BR_JMP:  taken_p0 = 1'b1;
      BR_BEQ:  taken_p0 = (bus.ex_val1 == bus.ex_val2);
      BR_BLT:  taken_p0 = (val1_s < val2_s);
      BR_BGE:  taken_p0 = (val1_s >= val2_s);
      BR_BLTU: taken_p0 = (bus.ex_val1 < bus.ex_val2);
      default: taken_p0 = 1'b0;
    endcase
  end

  assign active_p0  = bus.ex_valid && !bus.flush && !bus.stall && (type_p0 != BR_NONE);
  assign cond_p0    = (type_p0 != BR_NONE) && (type_p0 != BR_JMP);
  assign mispred_p0 = active_p0 && (taken_p0 != bus.ex_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (active_p0 && cond_p0) begin
      bht[ex_idx] <= bht_step(bht[ex_idx], taken_p0);
    end
  end

  // Stage p1: registered result and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_p1   <= 1'b0;
      res_taken_p1   <= 1'b0;
      mispredict_p1  <= 1'b0;
      branch_cnt_p1  <= '0;
      mispred_cnt_p1 <= '0;
    end else begin
      res_valid_p1  <= active_p0;
      res_taken_p1  <= active_p0 && taken_p0;
      mispredict_p1 <= mispred_p0;
      if (active_p0)  branch_cnt_p1  <= sat_inc(branch_cnt_p1);
      if (mispred_p0) mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
    end
  end

  assign bus.res_valid        = res_valid_p1;
  assign bus.res_taken        = res_taken_p1;
  assign bus.mispredict       = mispredict_p1;
  assign bus.branch_count     = branch_cnt_p1;
  assign bus.mispredict_count = mispred_cnt_p1;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit. A behavioural model tracks
// the BHT and statistics. A second instance with 4-bit counters shares the stimulus.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WIDTH(32), .CNT_WIDTH(16)) bus   ();
  branch_resolve_unit_if #(.WIDTH(32), .CNT_WIDTH(4))  bus_s ();

  assign bus_s.id_pc          = bus.id_pc;
  assign bus_s.ex_valid       = bus.ex_valid;
  assign bus_s.ex_pc          = bus.ex_pc;
  assign bus_s.ex_val1        = bus.ex_val1;
  assign bus_s.ex_val2        = bus.ex_val2;
  assign bus_s.ex_branch_type = bus.ex_branch_type;
  assign bus_s.ex_pred_taken  = bus.ex_pred_taken;
  assign bus_s.stall          = bus.stall;
  assign bus_s.flush          = bus.flush;

  branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(16), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  int tests = 0;
  int fails = 0;

  int m_bht [16];
  bit m_rv, m_rt, m_mp;
  int m_bc, m_mc;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit outcome(input bit [2:0] t, input bit [31:0] a, input bit [31:0] b);
    case (t)
      3'd1: return a == 0;
      3'd2: return a != b;
      3'd3: return 1'b1;
      3'd4: return a == b;
      3'd5: return $signed(a) <  $signed(b);
      3'd6: return $signed(a) >= $signed(b);
      3'd7: return a < b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int clamp(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_rv = 0; m_rt = 0; m_mp = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_regs();
    chk("res_valid", bus.res_valid, m_rv);
    if (m_rv) chk("res_taken", bus.res_taken, m_rt);
    chk("mispredict", bus.mispredict, m_mp);
    chk("branch_count", bus.branch_count, clamp(m_bc, 65535));
    chk("mispredict_count", bus.mispredict_count, clamp(m_mc, 65535));
    chk("branch_count_w4", bus_s.branch_count, clamp(m_bc, 15));
    chk("mispredict_count_w4", bus_s.mispredict_count, clamp(m_mc, 15));
  endtask

  // One EX cycle: check registered state, drive, check the lookup, advance the model
  task automatic step(input bit v, input bit [31:0] pc, input bit [31:0] a,
                      input bit [31:0] b, input bit [2:0] t, input bit p,
                      input bit st, input bit fl, input bit [31:0] idpc);
    bit act, tk;
    @(negedge clk);
    check_regs();
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_val1 = a; bus.ex_val2 = b;
    bus.ex_branch_type = t; bus.ex_pred_taken = p; bus.stall = st; bus.flush = fl;
    bus.id_pc = idpc;
    #1;
    chk("pred_taken", bus.pred_taken, m_bht[idpc[5:2]] >> 1);
    act = v && !st && !fl && (t != 0);
    tk  = outcome(t, a, b);
    m_rv = act;
    m_rt = tk;
    m_mp = act && (tk != p);
    if (act) begin
      m_bc++;
      if (m_mp) m_mc++;
      if (t != 3'd3) begin
        if (tk && m_bht[pc[5:2]] < 3) m_bht[pc[5:2]]++;
        if (!tk && m_bht[pc[5:2]] > 0) m_bht[pc[5:2]]--;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string name, input bit [31:0] idpc, input bit exp);
    bus.id_pc = idpc;
    #1;
    chk(name, bus.pred_taken, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  bit [31:0] ext [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    bit [31:0] a, b, pc, idpc;
    bit [2:0]  sel;
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_val1 = 0; bus.ex_val2 = 0;
    bus.ex_branch_type = 0; bus.ex_pred_taken = 0; bus.stall = 0; bus.flush = 0;
    bus.id_pc = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_branch_count", bus.branch_count, 0);
    lookup("rst_pred_0x40", 32'h40, 0);
    lookup("rst_pred_0x3c", 32'h3c, 0);
    rst_n = 1'b1;

    // Same-cycle lookup and update of an entry at 01
    step(1, 32'h104, 5, 5, 3'd4, 1, 0, 0, 32'h104);
    chk("bypass_same_cycle", bus.pred_taken, 0);
    settle();
    chk("bypass_next_cycle", bus.pred_taken, 1);

    // Signed vs unsigned less-than on 0xFFFFFFFF vs 1
    step(1, 32'h8, 32'hFFFF_FFFF, 1, 3'd5, 0, 0, 0, 0);
    settle();
    chk("blt_taken", bus.res_taken, 1);
    chk("blt_mispredict", bus.mispredict, 1);
    chk("blt_mcount", bus.mispredict_count, 1);
    step(1, 32'h8, 32'hFFFF_FFFF, 1, 3'd7, 0, 0, 0, 0);
    settle();
    chk("bltu_valid", bus.res_valid, 1);
    chk("bltu_taken", bus.res_taken, 0);
    chk("bltu_mispredict", bus.mispredict, 0);

    // Taken BEQs saturate the entry and the alias at 0x80 sees it
    step(1, 32'h40, 5, 5, 3'd4, 0, 0, 0, 0);
    step(1, 32'h40, 5, 5, 3'd4, 0, 0, 0, 0);
    settle();
    lookup("beq_pred_0x40", 32'h40, 1);
    lookup("beq_pred_0x80", 32'h80, 1);
    step(1, 32'h40, 5, 5, 3'd4, 0, 0, 0, 32'h40);
    settle();
    chk("beq_sat_pred", bus.pred_taken, 1);
    chk("beq_mcount", bus.mispredict_count, 4);

    // Stall and flush suppress everything
    step(1, 32'h10, 1, 2, 3'd2, 0, 1, 0, 32'h10);
    settle();
    chk("stall_no_valid", bus.res_valid, 0);
    step(1, 32'h10, 1, 2, 3'd2, 0, 0, 1, 32'h10);
    settle();
    chk("flush_no_valid", bus.res_valid, 0);
    step(1, 32'h10, 1, 2, 3'd2, 0, 1, 1, 32'h10);
    settle();
    chk("flush_stall_no_valid", bus.res_valid, 0);
    chk("suppressed_bcount", bus.branch_count, 6);
    chk("suppressed_pred", bus.pred_taken, 0);

    // Reset arrives while a result is pending
    step(1, 32'h44, 0, 9, 3'd1, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    reset_model();
    settle();
    chk("midrst_valid", bus.res_valid, 0);
    chk("midrst_mispredict", bus.mispredict, 0);
    chk("midrst_bcount", bus.branch_count, 0);
    lookup("midrst_pred", 32'h40, 0);
    settle();
    rst_n = 1'b1;
    step(1, 32'h200, 5, 5, 3'd4, 0, 0, 0, 0);
    settle();
    chk("first_edge_valid", bus.res_valid, 1);
    chk("first_edge_bcount", bus.branch_count, 1);
    chk("first_edge_mcount", bus.mispredict_count, 1);
    idle();

    for (int i = 0; i < 3000; i++) begin
      sel = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (sel == 1) b = a;
      if (sel == 2) a = 0;
      if (sel == 3) begin
        a = ext[$urandom_range(0, 4)];
        b = ext[$urandom_range(0, 4)];
      end
      pc   = $urandom & 32'hFF;
      idpc = ($urandom_range(0, 3) == 0) ? pc : ($urandom & 32'hFF);
      step(($urandom_range(0, 7) != 0), pc, a, b, 3'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), idpc);
    end
    idle();
    @(negedge clk);
    check_regs();
    chk("w4_saturated", bus_s.branch_count, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
